// File: rtl/axi_mmio_pkg.sv
// Shared encodings for the MMIO device window: register indices, AXI response
// and burst codes, FSM states and per-beat helper functions.
package axi_mmio_pkg;

  typedef enum logic [1:0] {
    REG_MTIME     = 2'd0,
    REG_MTIMECMP  = 2'd1,
    REG_SERIAL_TX = 2'd2,
    REG_SCRATCH   = 2'd3
  } reg_idx_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B = 3'd3;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  // Address-derived response of one beat; decode failure outranks format errors.
  function automatic logic [1:0] beat_resp(input logic       in_window,
                                           input logic [2:0] byte_off,
                                           input logic [2:0] size,
                                           input logic [1:0] burst);
    if (!in_window) return RESP_DECERR;
    if (byte_off != 3'd0 || size != SIZE_8B || burst == BURST_WRAP) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_mmio_slave_regfile.sv
// Device registers: free-running mtime, mtimecmp with registered timer irq,
// scratch, and the serial transmit pulse. Reads are combinational.
module axi_mmio_slave_regfile
  import axi_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rd_addr,
  output logic [63:0] rd_data,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [63:0] scratch;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      REG_MTIME:    rd_data = mtime;
      REG_MTIMECMP: rd_data = mtimecmp;
      REG_SCRATCH:  rd_data = scratch;
      default:      rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      scratch   <= '0;
      timer_irq <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      tx_valid  <= 1'b0;
      timer_irq <= (mtime >= mtimecmp);

      // A software write to mtime replaces that cycle's increment.
      if (wr_en && wr_addr == REG_MTIME) mtime <= strb_merge(mtime, wr_data, wr_strb);
      else                               mtime <= mtime + 64'd1;

      if (wr_en) begin
        case (wr_addr)
          REG_MTIMECMP: mtimecmp <= strb_merge(mtimecmp, wr_data, wr_strb);
          REG_SCRATCH:  scratch  <= strb_merge(scratch, wr_data, wr_strb);
          REG_SERIAL_TX: begin
            if (wr_strb[0]) begin
              tx_valid <= 1'b1;
              tx_data  <= wr_data[7:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/axi_mmio_slave.sv
// AXI4 responder for the 32-byte device window: independent read and write
// burst FSMs in front of axi_mmio_slave_regfile.
module axi_mmio_slave
  import axi_mmio_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = 64'h0200_0000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETn,

  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic [3:0]                      S_AXI_ARCACHE,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic [3:0]                      S_AXI_ARQOS,
  input  logic [3:0]                      S_AXI_ARREGION,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,

  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,

  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic [3:0]                      S_AXI_AWCACHE,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic [3:0]                      S_AXI_AWQOS,
  input  logic [3:0]                      S_AXI_AWREGION,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,

  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,

  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,

  output logic                            timer_irq,
  output logic                            tx_valid,
  output logic [7:0]                      tx_data
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] BEAT_BYTES = {{(AW-4){1'b0}}, 4'd8};

  // Cache/prot/qos/region carry no meaning for a register window.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
                           S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION};

  r_state_e r_state;
  w_state_e w_state;

  logic [AW-1:0] r_addr, r_next_addr, rd_cur_addr, rd_off;
  logic [7:0]    r_cnt;
  logic [2:0]    r_size, rd_cur_size;
  logic [1:0]    r_burst, rd_cur_burst, rd_resp;
  logic          rd_in_window;
  logic [63:0]   rf_rd_data;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_beat_data;

  logic [AW-1:0] w_addr, w_next_addr, w_off;
  logic [7:0]    w_cnt;
  logic [2:0]    w_size;
  logic [1:0]    w_burst, w_addr_resp, w_beat_resp, w_resp_acc, w_resp_next;
  logic          w_in_window, w_len_err, w_hs, wr_en;

  // The beat loaded at a handshake is the AR address when idle, else the next burst address.
  assign r_next_addr = (r_burst == BURST_FIXED) ? r_addr : r_addr + BEAT_BYTES;

  always_comb begin
    rd_cur_addr  = r_next_addr;
    rd_cur_size  = r_size;
    rd_cur_burst = r_burst;
    if (r_state == R_IDLE) begin
      rd_cur_addr  = S_AXI_ARADDR;
      rd_cur_size  = S_AXI_ARSIZE;
      rd_cur_burst = S_AXI_ARBURST;
    end
  end

  assign rd_off       = rd_cur_addr - BASE_ADDR;
  assign rd_in_window = (rd_off[AW-1:5] == '0);
  assign rd_resp      = beat_resp(rd_in_window, rd_off[2:0], rd_cur_size, rd_cur_burst);
  assign rd_beat_data = (rd_resp == RESP_OKAY) ? rf_rd_data : '0;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RID     <= '0;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RID     <= S_AXI_ARID;
            r_addr        <= S_AXI_ARADDR;
            r_cnt         <= S_AXI_ARLEN;
            r_size        <= S_AXI_ARSIZE;
            r_burst       <= S_AXI_ARBURST;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            S_AXI_RDATA   <= rd_beat_data;
            S_AXI_RRESP   <= rd_resp;
            r_state       <= R_BURST;
          end
        end
        R_BURST: begin
          if (S_AXI_RREADY) begin
            if (r_cnt == 8'd0) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next_addr;
              r_cnt       <= r_cnt - 8'd1;
              S_AXI_RLAST <= (r_cnt == 8'd1);
              S_AXI_RDATA <= rd_beat_data;
              S_AXI_RRESP <= rd_resp;
            end
          end
        end
      endcase
    end
  end

  assign w_next_addr = (w_burst == BURST_FIXED) ? w_addr : w_addr + BEAT_BYTES;
  assign w_off       = w_addr - BASE_ADDR;
  assign w_in_window = (w_off[AW-1:5] == '0);
  assign w_addr_resp = beat_resp(w_in_window, w_off[2:0], w_size, w_burst);
  assign w_len_err   = S_AXI_WLAST != (w_cnt == 8'd0);
  assign w_beat_resp = (w_addr_resp != RESP_OKAY) ? w_addr_resp :
                       (w_len_err ? RESP_SLVERR : RESP_OKAY);
  assign w_resp_next = (w_resp_acc != RESP_OKAY) ? w_resp_acc : w_beat_resp;
  assign w_hs        = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;
  // A length mismatch only affects BRESP; address-level errors suppress the write.
  assign wr_en       = w_hs && (w_addr_resp == RESP_OKAY);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_BID     <= '0;
      w_addr        <= '0;
      w_cnt         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_resp_acc    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_BID     <= S_AXI_AWID;
            w_addr        <= S_AXI_AWADDR;
            w_cnt         <= S_AXI_AWLEN;
            w_size        <= S_AXI_AWSIZE;
            w_burst       <= S_AXI_AWBURST;
            w_resp_acc    <= RESP_OKAY;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_resp_acc <= w_resp_next;
            w_addr     <= w_next_addr;
            if (w_cnt != 8'd0) w_cnt <= w_cnt - 8'd1;
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= w_resp_next;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  axi_mmio_slave_regfile u_regfile (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETn),
    .rd_addr   (rd_off[4:3]),
    .rd_data   (rf_rd_data),
    .wr_en     (wr_en),
    .wr_addr   (w_off[4:3]),
    .wr_data   (S_AXI_WDATA),
    .wr_strb   (S_AXI_WSTRB),
    .timer_irq (timer_irq),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data)
  );

endmodule

// File: tb/tb_axi_mmio_slave.sv
// Scoreboard bench for axi_mmio_slave: expected R/B beats are queued as
// stimulus is issued and compared when the DUT hands them over.
module tb_axi_mmio_slave;

  localparam logic [63:0] BASE   = 64'h0200_0000;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;
  localparam logic [1:0]  FIXED  = 2'b00;
  localparam logic [1:0]  INCR   = 2'b01;
  localparam logic [1:0]  WRAP   = 2'b10;

  logic        clk;
  logic        rst_n;
  logic [0:0]  arid, rid, awid, bid;
  logic [63:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen, wstrb, tx_data;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        timer_irq, tx_valid;

  typedef struct {
    logic [0:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [0:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  r_exp_t      r_e;
  b_exp_t      b_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          tx_count = 0;
  logic [7:0]  tx_last  = 8'h00;
  logic [63:0] cyc;
  logic [63:0] exp_scratch = 64'd0;
  logic        r_hold_v = 1'b0;
  logic [63:0] r_hold   = 64'd0;

  axi_mmio_slave dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETn  (rst_n),
    .S_AXI_ARID     (arid),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARLEN    (arlen),
    .S_AXI_ARSIZE   (arsize),
    .S_AXI_ARBURST  (arburst),
    .S_AXI_ARCACHE  (4'd0),
    .S_AXI_ARPROT   (3'd0),
    .S_AXI_ARQOS    (4'd0),
    .S_AXI_ARREGION (4'd0),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RID      (rid),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RLAST    (rlast),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready),
    .S_AXI_AWID     (awid),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWLEN    (awlen),
    .S_AXI_AWSIZE   (awsize),
    .S_AXI_AWBURST  (awburst),
    .S_AXI_AWCACHE  (4'd0),
    .S_AXI_AWPROT   (3'd0),
    .S_AXI_AWQOS    (4'd0),
    .S_AXI_AWREGION (4'd0),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WLAST    (wlast),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BID      (bid),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .timer_irq      (timer_irq),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time base: cycles since reset release, i.e. the value MTIME must hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 64'd0;
    else        cyc <= cyc + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: samples on the falling edge, inputs change just after the rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      r_hold_v = 1'b0;
    end else begin
      if (r_hold_v) begin
        check("r_valid_held", 64'(rvalid), 64'd1);
        check("r_stable", rdata, r_hold);
      end
      r_hold_v = rvalid && !rready;
      r_hold   = rdata;
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          check("r_unexpected", 64'(rq.size()), 64'd1);
        end else begin
          r_e = rq.pop_front();
          check("rid",   64'(rid),   64'(r_e.id));
          check("rdata", rdata,      r_e.data);
          check("rresp", 64'(rresp), 64'(r_e.resp));
          check("rlast", 64'(rlast), 64'(r_e.last));
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          check("b_unexpected", 64'(bq.size()), 64'd1);
        end else begin
          b_e = bq.pop_front();
          check("bid",   64'(bid),   64'(b_e.id));
          check("bresp", 64'(bresp), 64'(b_e.resp));
        end
      end
      if (tx_valid) begin
        tx_count++;
        tx_last = tx_data;
      end
    end
  end

  task automatic push_r(input logic [0:0] id, input logic [63:0] data,
                        input logic [1:0] resp, input logic last);
    rq.push_back('{id, data, resp, last});
  endtask

  task automatic ar_send(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, output logic [63:0] t_hs);
    int n;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_hs", 64'(arready), 64'd1);
    t_hs = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    int n;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = INCR; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("aw_hs", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb);
    int n;
    @(posedge clk); #1;
    wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w_hs", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(rq.size() + bq.size()), 64'd0);
  endtask

  task automatic axi_write(input logic [0:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [63:0] data, input logic [7:0] strb,
                           input logic [1:0] exp_resp);
    aw_send(id, addr, len, size);
    bq.push_back('{id, exp_resp});
    w_send(data, strb);
    drain();
  endtask

  // Single-beat read; with is_mtime the expectation is the time base at the AR handshake.
  task automatic rd_check(input logic [0:0] id, input logic [63:0] addr, input logic [1:0] burst,
                          input logic is_mtime, input logic [63:0] exp_data, input logic [1:0] exp_resp);
    logic [63:0] t;
    ar_send(id, addr, 8'd0, burst, t);
    push_r(id, is_mtime ? t : exp_data, exp_resp, 1'b1);
    drain();
  endtask

  initial begin : main
    int n;
    logic [63:0] t;
    rst_n = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_tx",      64'({tx_valid, tx_data}), 64'd0);
    check("rst_irq",     64'(timer_irq), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("arready_idle", 64'(arready), 64'd1);

    // MTIME after idling, with exact one-cycle read latency.
    repeat (10) @(posedge clk);
    ar_send(1'b0, BASE, 8'd0, INCR, t);
    push_r(1'b0, t, OKAY, 1'b1);
    @(negedge clk);
    check("r_latency", 64'(rvalid), 64'd1);
    drain();

    // Timer compare.
    axi_write(1'b0, BASE + 64'h08, 8'd0, 3'd3, 64'h40, 8'hFF, OKAY);
    n = 0;
    @(negedge clk);
    while (cyc != 64'h40 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("irq_reach", cyc, 64'h40);
    check("irq_before", 64'(timer_irq), 64'd0);
    @(negedge clk);
    check("irq_rise", 64'(timer_irq), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("irq_hold", 64'(timer_irq), 64'd1);
    end

    // INCR burst over the whole window with RREADY toggling.
    ar_send(1'b0, BASE, 8'd3, INCR, t);
    push_r(1'b0, t, OKAY, 1'b0);
    push_r(1'b0, 64'h40, OKAY, 1'b0);
    push_r(1'b0, 64'd0, OKAY, 1'b0);
    push_r(1'b0, exp_scratch, OKAY, 1'b1);
    n = 0;
    while (rq.size() != 0 && n < 40) begin
      @(negedge clk);
      @(posedge clk); #1;
      rready = ~rready;
      n++;
    end
    rready = 1'b1;
    drain();

    // Serial transmit: only a write with byte 0 enabled emits a byte.
    axi_write(1'b0, BASE + 64'h10, 8'd0, 3'd3, 64'h41, 8'h01, OKAY);
    axi_write(1'b0, BASE + 64'h10, 8'd0, 3'd3, 64'h5A5A, 8'hFE, OKAY);
    repeat (2) @(negedge clk);
    check("tx_count", 64'(tx_count), 64'd1);
    check("tx_data",  64'(tx_last),  64'h41);

    // Error responses.
    rd_check(1'b0, BASE + 64'h20, INCR, 1'b0, 64'd0, DECERR);
    rd_check(1'b0, BASE - 64'h08, INCR, 1'b0, 64'd0, DECERR);
    rd_check(1'b0, BASE + 64'h08, WRAP, 1'b0, 64'd0, SLVERR);
    axi_write(1'b0, BASE + 64'h04, 8'd0, 3'd3, '1, 8'hFF, SLVERR);
    axi_write(1'b0, BASE + 64'h1C, 8'd0, 3'd3, '1, 8'hFF, SLVERR);
    axi_write(1'b0, BASE + 64'h18, 8'd0, 3'd2, '1, 8'hFF, SLVERR);
    axi_write(1'b0, BASE + 64'h18, 8'd1, 3'd3, 64'd0, 8'h00, SLVERR);
    rd_check(1'b0, BASE + 64'h18, INCR, 1'b0, exp_scratch, OKAY);
    rd_check(1'b0, BASE, INCR, 1'b1, 64'd0, OKAY);

    // Concurrent SCRATCH write and read: the read sees the pre-write value.
    aw_send(1'b1, BASE + 64'h18, 8'd0, 3'd3);
    bq.push_back('{1'b1, OKAY});
    push_r(1'b1, exp_scratch, OKAY, 1'b1);
    wdata = 64'hDEAD; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
    arid = 1'b1; araddr = BASE + 64'h18; arlen = 8'd0; arsize = 3'd3; arburst = INCR; arvalid = 1'b1;
    @(negedge clk);
    check("conc_wready",  64'(wready),  64'd1);
    check("conc_arready", 64'(arready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0; arvalid = 1'b0;
    drain();
    exp_scratch = 64'hDEAD;
    rd_check(1'b1, BASE + 64'h18, INCR, 1'b0, exp_scratch, OKAY);

    // FIXED burst repeats the same register.
    ar_send(1'b1, BASE + 64'h18, 8'd1, FIXED, t);
    push_r(1'b1, exp_scratch, OKAY, 1'b0);
    push_r(1'b1, exp_scratch, OKAY, 1'b1);
    drain();

    // Reset in the middle of a stalled burst abandons it.
    rready = 1'b0;
    ar_send(1'b0, BASE, 8'd3, INCR, t);
    @(negedge clk);
    check("burst_active", 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid",  64'(rvalid),  64'd0);
    check("mid_rst_arready", 64'(arready), 64'd0);
    check("mid_rst_irq",     64'(timer_irq), 64'd0);
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rready = 1'b1;
    exp_scratch = 64'd0;
    repeat (3) @(posedge clk);
    rd_check(1'b0, BASE + 64'h18, INCR, 1'b0, exp_scratch, OKAY);
    rd_check(1'b0, BASE + 64'h08, INCR, 1'b0, '1, OKAY);
    rd_check(1'b0, BASE, INCR, 1'b1, 64'd0, OKAY);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
